// File: rtl/text_render_param_if.sv
// CPU write bus into the text renderer's character/attribute RAM.
// master: CPU side drives strobe/select/address/data; slave: renderer.
interface text_render_param_if #(
  parameter int AW = 12
);
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data
  );

  modport slave (
    input wr_en, wr_sel, wr_addr, wr_data
  );
endinterface

// File: rtl/text_render_param.sv
// Text-mode renderer: char/attr RAM, font fetch, cursor, underline,
// border. Ports: clk, rst (async, active-low), hcnt/vcnt/visible
// timing in, bus (CPU writes), color/cur_* controls, font_addr out,
// font_data in (1-clk ROM), rgb out (registered, 1 clk after inputs).
module text_render_param #(
  parameter int          COLS      = 64,
  parameter int          ROWS      = 32,
  parameter int          CHAR_H    = 10,
  parameter int          FONT_SH   = 4,
  parameter int          SCALE     = 2,
  parameter int          H_ORG     = 162,
  parameter int          V_ORG     = 63,
  parameter int          CUR_LINES = 2,
  parameter int          BLINK_FR  = 16,
  parameter logic [23:0] BORDER    = 24'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [10:0]          hcnt,
  input  logic [10:0]          vcnt,
  input  logic                 visible,
  text_render_param_if.slave   bus,
  input  logic                 color,
  input  logic                 cur_en,
  input  logic [7:0]           cur_col,
  input  logic [7:0]           cur_row,
  output logic [FONT_SH+7:0]   font_addr,
  input  logic [7:0]           font_data,
  output logic [23:0]          rgb
);

  localparam int CELLS = COLS * ROWS;
  // One extra bit so the first out-of-range cell index is
  // expressible on the bus and can be rejected.
  localparam int AW  = $clog2(CELLS + 1);
  localparam int IW  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW  = $clog2(COLS + 1);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW  = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int BLW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  localparam logic [11:0] H_BEG = 12'(H_ORG);
  localparam logic [11:0] H_END = 12'(H_ORG + 8*SCALE*COLS);
  localparam logic [11:0] V_BEG = 12'(V_ORG);
  localparam logic [11:0] V_END = 12'(V_ORG + CHAR_H*SCALE*ROWS);
  localparam logic [10:0] H_FST = 11'(H_ORG - 8*SCALE);
  localparam logic [10:0] V_CLR = 11'(V_ORG - 1);

  localparam logic [SW-1:0]  S_MAX  = SW'(SCALE - 1);
  localparam logic [LW-1:0]  L_MAX  = LW'(CHAR_H - 1);
  localparam logic [LW-1:0]  L_CUR  = LW'(CHAR_H - CUR_LINES);
  localparam logic [RW-1:0]  R_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0]  C_END  = CW'(COLS);
  localparam logic [IW-1:0]  COLS_I = IW'(COLS);
  localparam logic [AW-1:0]  CELL_A = AW'(CELLS);
  localparam logic [BLW-1:0] B_MAX  = BLW'(BLINK_FR - 1);
  localparam logic [23:0]    MONO   = 24'h00C00B;

  logic [7:0] cram [CELLS];
  logic [7:0] aram [CELLS];

  logic          h_run;
  logic [SW-1:0] f_sub;
  logic [2:0]    f_bit;
  logic [CW-1:0] f_col;
  logic [2:0]    stg;
  logic [7:0]    ch_q, at_q;
  logic [CW-1:0] col_p;
  logic [7:0]    attr_l;
  logic [7:0]    glyph_l;
  logic [6:0]    attr_l2;
  logic [7:0]    sh;
  logic [6:0]    d_attr;

  logic [SW-1:0] v_sub, n_sub;
  logic [LW-1:0] v_line, n_line;
  logic [RW-1:0] v_row, n_row;
  logic [IW-1:0] v_base, n_base;

  logic [BLW-1:0] b_cnt;
  logic           blink;

  logic          start, act;
  logic [SW-1:0] c_sub;
  logic [2:0]    c_bit;
  logic [CW-1:0] c_col;
  logic          last_px, cell_end, f0;
  logic [IW-1:0] rd_addr;
  logic          v_adv, v_clr, frame, in_win, cur_hit;
  logic [7:0]    gmod, fgl;
  logic [23:0]   fg, bg, px, nxt_rgb;

  assign frame = (hcnt == '0) && (vcnt == '0);
  assign v_clr = (vcnt == V_CLR) || (vcnt == '0);
  assign v_adv = (hcnt == '0) && ({1'b0, vcnt} > V_BEG);

  assign in_win = ({1'b0, hcnt} >= H_BEG) &&
                  ({1'b0, hcnt} <  H_END) &&
                  ({1'b0, vcnt} >= V_BEG) &&
                  ({1'b0, vcnt} <  V_END);

  // Fetch runs one cell ahead of display; the extra cell at the
  // end keeps sub/bit stepping alive while the last cell shifts out.
  assign start    = (hcnt == H_FST);
  assign act      = start | h_run;
  assign c_sub    = start ? '0 : f_sub;
  assign c_bit    = start ? '0 : f_bit;
  assign c_col    = start ? '0 : f_col;
  assign last_px  = (c_sub == S_MAX);
  assign cell_end = last_px && (c_bit == 3'd7);
  assign f0       = act && (c_bit == '0) &&
                    (c_sub == '0) && (c_col < C_END);

  // Vertical step for the next scanline, shared by the fetch
  // address so an advance on the F0 edge reads the new row.
  always_comb begin
    n_sub  = v_sub + SW'(1);
    n_line = v_line;
    n_row  = v_row;
    n_base = v_base;
    if (v_sub == S_MAX) begin
      n_sub  = '0;
      n_line = v_line + LW'(1);
      if (v_line == L_MAX) begin
        n_line = '0;
        if (v_row == R_MAX) begin
          n_row  = '0;
          n_base = '0;
        end else begin
          n_row  = v_row + RW'(1);
          n_base = v_base + COLS_I;
        end
      end
    end
  end

  assign rd_addr = (v_adv ? n_base : v_base) + IW'(c_col);

  assign cur_hit = cur_en && blink &&
                   (int'(v_row) == int'(cur_row)) &&
                   (int'(col_p) == int'(cur_col)) &&
                   (v_line >= L_CUR);

  always_comb begin
    gmod = font_data;
    if (attr_l[7] && (v_line == L_MAX))
      gmod = 8'hFF;
    if (cur_hit)
      gmod = ~gmod;
  end

  always_comb begin
    fgl = d_attr[3] ? 8'hFF : 8'hC0;
    fg  = {d_attr[2] ? fgl : 8'h00,
           d_attr[1] ? fgl : 8'h00,
           d_attr[0] ? fgl : 8'h00};
    bg  = {{8{d_attr[6]}}, {8{d_attr[5]}}, {8{d_attr[4]}}};
    if (color)
      px = sh[7] ? fg : bg;
    else
      px = sh[7] ? MONO : 24'h0;
    if (!visible)
      nxt_rgb = 24'h0;
    else if (!in_win)
      nxt_rgb = BORDER;
    else
      nxt_rgb = px;
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && (bus.wr_addr < CELL_A)) begin
      if (bus.wr_sel)
        aram[bus.wr_addr[IW-1:0]] <= bus.wr_data;
      else
        cram[bus.wr_addr[IW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_run <= 1'b0;
      f_sub <= '0;
      f_bit <= '0;
      f_col <= '0;
    end else if (v_clr) begin
      h_run <= 1'b0;
      f_sub <= '0;
      f_bit <= '0;
      f_col <= '0;
    end else if (act) begin
      f_sub <= last_px ? '0 : c_sub + SW'(1);
      f_bit <= last_px ? c_bit + 3'd1 : c_bit;
      f_col <= c_col;
      h_run <= 1'b1;
      if (cell_end) begin
        if (c_col == C_END) begin
          f_col <= '0;
          h_run <= 1'b0;
        end else begin
          f_col <= c_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg       <= '0;
      ch_q      <= '0;
      at_q      <= '0;
      col_p     <= '0;
      attr_l    <= '0;
      font_addr <= '0;
      glyph_l   <= '0;
      attr_l2   <= '0;
      sh        <= '0;
      d_attr    <= '0;
    end else begin
      stg <= {stg[1:0], f0};
      if (f0) begin
        ch_q  <= cram[rd_addr];
        at_q  <= aram[rd_addr];
        col_p <= c_col;
      end
      if (stg[0]) begin
        font_addr <= {ch_q, FONT_SH'(v_line)};
        attr_l    <= at_q;
      end
      // ROM data for the F1 address is valid two cycles later.
      if (stg[2]) begin
        glyph_l <= gmod;
        attr_l2 <= attr_l[6:0];
      end
      if (act && cell_end) begin
        sh     <= glyph_l;
        d_attr <= attr_l2;
      end else if (act && last_px) begin
        sh <= {sh[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_sub  <= '0;
      v_line <= '0;
      v_row  <= '0;
      v_base <= '0;
    end else if (v_clr) begin
      v_sub  <= '0;
      v_line <= '0;
      v_row  <= '0;
      v_base <= '0;
    end else if (v_adv) begin
      v_sub  <= n_sub;
      v_line <= n_line;
      v_row  <= n_row;
      v_base <= n_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_cnt <= '0;
      blink <= 1'b0;
    end else if (frame) begin
      if (b_cnt == B_MAX) begin
        b_cnt <= '0;
        blink <= ~blink;
      end else begin
        b_cnt <= b_cnt + BLW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rgb <= '0;
    else
      rgb <= nxt_rgb;
  end

endmodule

// File: tb/tb_text_render_param.sv
// Directed bench for text_render_param: reset, colour/mono, underline,
// bounds, border/visible edges, blinking cursor, async reset.
module tb_text_render_param;

  localparam logic [23:0] BRD = 24'h123456;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcnt = '0;
  logic [10:0] vcnt = 11'd1000;
  logic        visible = 1'b0;
  logic        color = 1'b1;
  logic        cur_en = 1'b0;
  logic [7:0]  cur_col = '0;
  logic [7:0]  cur_row = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [23:0] rgb;

  logic [7:0]  rom [4096];
  logic [23:0] cap [2048];

  int n_chk = 0;
  int n_fail = 0;

  text_render_param_if #(.AW(12)) bus ();

  text_render_param #(
    .BLINK_FR (2),
    .BORDER   (BRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .visible   (visible),
    .bus       (bus.slave),
    .color     (color),
    .cur_en    (cur_en),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .font_addr (font_addr),
    .font_data (font_data),
    .rgb       (rgb)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    font_data <= rom[font_addr];

  task automatic chk(input string tag,
                     input logic [23:0] got,
                     input logic [23:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int h, input int v);
    hcnt = 11'(h);
    vcnt = 11'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s, input int a,
                    input logic [7:0] d);
    bus.wr_sel  = s;
    bus.wr_addr = 12'(a);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  // Clear line counters, step to scanline v, then sweep the
  // fetch/display region capturing rgb per hcnt.
  task automatic render(input int v, input int h1);
    tick(0, 62);
    for (int i = 63; i <= v; i++)
      tick(0, i);
    for (int h = 146; h <= h1; h++) begin
      tick(h, v);
      cap[h] = rgb;
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < 4096; i++)
      rom[i] = 8'h00;
    rom[12'h411] = 8'h80;
    rom[12'h011] = 8'h01;

    visible = 1'b1;
    hcnt = 11'd170;
    vcnt = 11'd70;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_rgb", rgb, 24'h0);
      chk("rst_fa", 24'(font_addr), 24'h0);
    end
    rst = 1'b1;
    vcnt = 11'd1000;
    hcnt = 11'd0;

    wr(1'b0, 0, 8'h41);
    wr(1'b1, 0, 8'h07);
    wr(1'b0, 5, 8'h00);
    wr(1'b1, 5, 8'h8F);
    wr(1'b0, 63, 8'h01);
    wr(1'b1, 63, 8'h07);
    wr(1'b0, 194, 8'h00);
    wr(1'b1, 194, 8'h24);

    render(65, 1190);
    chk("c0_p162", cap[162], 24'hC0C0C0);
    chk("c0_p163", cap[163], 24'hC0C0C0);
    chk("c0_p164", cap[164], 24'h000000);
    chk("edge_left", cap[161], BRD);
    chk("last_m2", cap[1183], 24'h000000);
    chk("last_m1", cap[1184], 24'hC0C0C0);
    chk("last_px", cap[1185], 24'hC0C0C0);
    chk("past_last", cap[1186], BRD);

    color = 1'b0;
    render(65, 170);
    chk("mono_on", cap[162], 24'h00C00B);
    chk("mono_off", cap[164], 24'h000000);
    color = 1'b1;

    render(81, 260);
    chk("ul_first", cap[242], 24'hFFFFFF);
    chk("ul_mid", cap[249], 24'hFFFFFF);
    chk("ul_last", cap[257], 24'hFFFFFF);
    render(79, 260);
    chk("ul_line8", cap[242], 24'h000000);

    wr(1'b0, 2048, 8'h55);
    wr(1'b1, 2048, 8'h00);
    render(65, 170);
    chk("bound_on", cap[162], 24'hC0C0C0);
    chk("bound_off", cap[164], 24'h000000);

    visible = 1'b0;
    tick(170, 65);
    chk("novis_win", rgb, 24'h0);
    tick(100, 40);
    chk("novis_out", rgb, 24'h0);
    visible = 1'b1;
    tick(100, 40);
    chk("border_top", rgb, BRD);
    tick(170, 703);
    chk("border_bot", rgb, BRD);

    cur_en  = 1'b1;
    cur_row = 8'd3;
    cur_col = 8'd2;
    for (int k = 1; k <= 5; k++) begin
      logic [23:0] exp;
      exp = (((k / 2) % 2) == 1) ? 24'hC00000 : 24'h00FF00;
      tick(0, 0);
      render(139, 212);
      chk($sformatf("cur_f%0d_a", k), cap[194], exp);
      chk($sformatf("cur_f%0d_b", k), cap[209], exp);
      if (k == 2) begin
        render(137, 212);
        chk("cur_line7", cap[194], 24'h00FF00);
      end
    end
    cur_en = 1'b0;

    render(65, 163);
    chk("pre_arst", rgb, 24'hC0C0C0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rgb", rgb, 24'h0);
    chk("arst_fa", 24'(font_addr), 24'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
